// File: rtl/regfile_bypass.sv
// regfile_bypass: parametrised register file with two combinational read
// ports, a same-cycle write-to-read bypass, an optional hardwired-zero
// register 0, and a per-register pending-write scoreboard. The scoreboard
// lets decode see read-after-write hazards against in-flight producers.
module regfile_bypass #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              busy1,
  output logic              busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              flush
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;

  logic wr_ok;
  logic issue_ok;
  logic hit1;
  logic hit2;

  // Register 0 swallows writes and issues when it is hardwired to zero.
  assign wr_ok    = wr_en    && !(HAS_ZERO && (wr_addr    == '0));
  assign issue_ok = issue_en && !(HAS_ZERO && (issue_addr == '0));

  // A writeback in flight to the read index is forwarded this cycle.
  assign hit1 = wr_en && (wr_addr == rd_addr1);
  assign hit2 = wr_en && (wr_addr == rd_addr2);

  // Storage update; reset clears every register asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Next pending vector: flush wins outright, otherwise clear then set so a
  // newly issued producer supersedes the one writing back this cycle.
  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      if (wr_en)    pend_d[wr_addr]    = 1'b0;
      if (issue_ok) pend_d[issue_addr] = 1'b1;
    end
  end

  // Pending scoreboard state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_q <= '0;
    else      pend_q <= pend_d;
  end

  // Read port 1: zero register, then bypass, then stored value.
  always_comb begin
    rd_data1 = regs_q[rd_addr1];
    if (hit1) rd_data1 = wr_data;
    if (HAS_ZERO && (rd_addr1 == '0)) rd_data1 = '0;
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rd_data2 = regs_q[rd_addr2];
    if (hit2) rd_data2 = wr_data;
    if (HAS_ZERO && (rd_addr2 == '0)) rd_data2 = '0;
  end

  // Busy drops in the same cycle the producer writes back.
  assign busy1 = pend_q[rd_addr1] & ~hit1;
  assign busy2 = pend_q[rd_addr2] & ~hit2;

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: directed vectors push expected values into a
// queue; a monitor on the falling edge pops and compares against the DUTs.
module tb_regfile_bypass;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance: 16 x 16, zero register on.
  logic [3:0]  ra1, ra2, wa, ia;
  logic [15:0] wd, d1, d2;
  logic        wen, ien, fl, b1, b2;

  // Wide instance: 32 x 32, no zero register.
  logic [4:0]  bra1, bra2, bwa, bia;
  logic [31:0] bwd, bd1, bd2;
  logic        bwen, bien, bfl, bb1, bb2;

  regfile_bypass #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst),
    .rd_addr1(ra1), .rd_addr2(ra2), .rd_data1(d1), .rd_data2(d2),
    .busy1(b1), .busy2(b2),
    .wr_en(wen), .wr_addr(wa), .wr_data(wd),
    .issue_en(ien), .issue_addr(ia), .flush(fl)
  );

  regfile_bypass #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst),
    .rd_addr1(bra1), .rd_addr2(bra2), .rd_data1(bd1), .rd_data2(bd2),
    .busy1(bb1), .busy2(bb2),
    .wr_en(bwen), .wr_addr(bwa), .wr_data(bwd),
    .issue_en(bien), .issue_addr(bia), .flush(bfl)
  );

  // Output selectors for scoreboard entries.
  localparam int A_D1 = 0, A_D2 = 1, A_B1 = 2, A_B2 = 3;
  localparam int B_D1 = 4, B_D2 = 5, B_B1 = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int sel, input logic [31:0] exp);
    q.push_back('{name, sel, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are stable by the falling edge.
  exp_t        e;
  logic [31:0] act;
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        A_D1:    act = {16'h0, d1};
        A_D2:    act = {16'h0, d2};
        A_B1:    act = {31'h0, b1};
        A_B2:    act = {31'h0, b2};
        B_D1:    act = bd1;
        B_D2:    act = bd2;
        default: act = {31'h0, bb1};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  initial begin
    ra1 = 0; ra2 = 0; wa = 0; ia = 0; wd = 0; wen = 0; ien = 0; fl = 0;
    bra1 = 0; bra2 = 0; bwa = 0; bia = 0; bwd = 0; bwen = 0; bien = 0; bfl = 0;
    #2 rst = 1'b0;

    // Writes and issues during reset are ignored, but bypass still forwards.
    step();
    wen = 1; wa = 2; wd = 16'hAAAA; ien = 1; ia = 2; ra1 = 2; ra2 = 2;
    chk("rst_bypass_d1", A_D1, 32'hAAAA);
    chk("rst_bypass_b1", A_B1, 0);
    step();
    wen = 0; ien = 0;
    chk("rst_nowrite_d1", A_D1, 0);
    chk("rst_noissue_b2", A_B2, 0);
    rst = 1'b1;

    // Every index reads zero and idle after reset.
    for (int i = 0; i < 16; i++) begin
      step();
      ra1 = 4'(i); ra2 = 4'(15 - i);
      chk("post_rst_d1", A_D1, 0);
      chk("post_rst_d2", A_D2, 0);
      chk("post_rst_b1", A_B1, 0);
      chk("post_rst_b2", A_B2, 0);
    end

    // Write with same-cycle bypass, then stored value.
    step();
    wen = 1; wa = 5; wd = 16'hBEEF; ra1 = 5; ra2 = 5;
    chk("bypass_d1", A_D1, 32'hBEEF);
    chk("bypass_d2", A_D2, 32'hBEEF);
    step();
    wen = 0;
    chk("stored_d1", A_D1, 32'hBEEF);
    chk("stored_d2", A_D2, 32'hBEEF);

    // Zero register ignores write and issue.
    step();
    wen = 1; wa = 0; wd = 16'h1234; ien = 1; ia = 0; ra1 = 0;
    chk("zero_same_d1", A_D1, 0);
    chk("zero_same_b1", A_B1, 0);
    step();
    wen = 0; ien = 0;
    chk("zero_after_d1", A_D1, 0);
    chk("zero_after_b1", A_B1, 0);

    // Scoreboard: issue to 7 shows busy after the edge, writeback clears.
    step();
    ien = 1; ia = 7; ra1 = 7; ra2 = 7;
    chk("issue_same_b1", A_B1, 0);
    step();
    ien = 0;
    chk("issue_next_b1", A_B1, 1);
    chk("issue_next_b2", A_B2, 1);
    step();
    chk("issue_hold_b1", A_B1, 1);
    step();
    wen = 1; wa = 7; wd = 16'hCAFE;
    chk("wb_same_b1", A_B1, 0);
    chk("wb_same_b2", A_B2, 0);
    chk("wb_same_d1", A_D1, 32'hCAFE);
    step();
    wen = 0;
    chk("wb_after_b1", A_B1, 0);
    chk("wb_after_d1", A_D1, 32'hCAFE);

    // Issue and write to the same index: set wins.
    step();
    ien = 1; ia = 3; ra1 = 3; ra2 = 3;
    step();
    ien = 1; ia = 3; wen = 1; wa = 3; wd = 16'h0333;
    chk("simul_b1", A_B1, 0);
    chk("simul_d1", A_D1, 32'h0333);
    step();
    ien = 1; ia = 9; wen = 0; ra2 = 9;
    chk("simul_kept_b1", A_B1, 1);
    // Flush clears everything, including the same-cycle issue.
    step();
    fl = 1; ien = 1; ia = 3; wen = 1; wa = 3; wd = 16'h0444;
    chk("flush_cyc_b1", A_B1, 0);
    chk("flush_cyc_b2_old", A_B2, 1);
    step();
    fl = 0; ien = 0; wen = 0;
    chk("flush_b1", A_B1, 0);
    chk("flush_b2", A_B2, 0);
    chk("flush_write_d1", A_D1, 32'h0444);

    // Load 1..15 and mark all pending, then pulse reset between edges.
    for (int i = 1; i < 16; i++) begin
      step();
      wen = 1; wa = 4'(i); wd = 16'h1000 + 16'(i); ien = 1; ia = 4'(i);
    end
    step();
    wen = 0; ien = 0; ra1 = 4; ra2 = 15;
    chk("loaded_d1", A_D1, 32'h1004);
    chk("loaded_d2", A_D2, 32'h100F);
    chk("loaded_b1", A_B1, 1);
    chk("loaded_b2", A_B2, 1);
    step();
    rst = 1'b0;
    chk("async_d1", A_D1, 0);
    chk("async_d2", A_D2, 0);
    chk("async_b1", A_B1, 0);
    chk("async_b2", A_B2, 0);
    step();
    rst = 1'b1;

    // Wide instance: index 0 writable, index 31 on port 2, index 0 busy.
    step();
    bwen = 1; bwa = 0; bwd = 32'hDEADBEEF; bra1 = 0; bra2 = 31;
    chk("w_bypass0_d1", B_D1, 32'hDEADBEEF);
    step();
    bwa = 31; bwd = 32'h12345678; bien = 1; bia = 0;
    chk("w_stored0_d1", B_D1, 32'hDEADBEEF);
    chk("w_bypass31_d2", B_D2, 32'h12345678);
    step();
    bwen = 0; bien = 0;
    chk("w_stored31_d2", B_D2, 32'h12345678);
    chk("w_busy0_b1", B_B1, 1);

    // Drain the scoreboard with a bounded wait.
    begin
      int k = 0;
      while (q.size() > 0 && k < 10) begin
        @(posedge clk);
        k++;
      end
      if (q.size() > 0) begin
        errors++;
        $display("FAIL drain: got %0d pending entries expected 0", q.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
